// File: rtl/crc16_ccitt_checker_if.sv
// Byte-stream and result bundle between the byte receiver, CRC checker and packet buffer.
interface crc16_ccitt_checker_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 data_valid;
  logic                 data_last;
  logic                 frame_abort;
  logic [7:0]           data_in;
  logic [15:0]          crc_out;
  logic                 busy;
  logic                 result_valid;
  logic                 crc_ok;
  logic                 crc_error;
  logic                 short_frame;
  logic [CNT_WIDTH-1:0] byte_count;

  modport master (
    output data_valid, data_last, frame_abort, data_in,
    input  crc_out, busy, result_valid, crc_ok, crc_error, short_frame, byte_count
  );

  modport slave (
    input  data_valid, data_last, frame_abort, data_in,
    output crc_out, busy, result_valid, crc_ok, crc_error, short_frame, byte_count
  );
endinterface

// File: rtl/crc16_ccitt_checker.sv
// CRC-16-CCITT residue checker: frames end with the CRC MSB first, a good frame leaves residue 0.
module crc16_ccitt_checker #(
  parameter logic [15:0] POLY       = 16'h1021,
  parameter logic [15:0] INIT_VALUE = 16'hFFFF,
  parameter int          MIN_LEN    = 3,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  crc16_ccitt_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_LEN);

  state_t               state;
  logic [15:0]          crc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 rvalid, ok, err, short_f;
  logic [CNT_WIDTH-1:0] bcount;

  logic                 accept;
  logic [15:0]          crc_next;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 is_short, good;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
    return r;
  endfunction

  // Only ACCUM continues a frame; a byte seen in IDLE or REPORT starts a fresh one.
  assign accept   = bus.data_valid & ~bus.frame_abort;
  assign crc_next = crc_byte((state == ACCUM) ? crc : INIT_VALUE, bus.data_in);
  assign cnt_next = (state != ACCUM) ? CNT_WIDTH'(1) :
                    (&cnt)           ? cnt : cnt + 1'b1;
  assign is_short = cnt_next < MIN_CNT;
  assign good     = (crc_next == 16'h0000) & ~is_short;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state   <= IDLE;
      crc     <= INIT_VALUE;
      cnt     <= '0;
      rvalid  <= 1'b0;
      ok      <= 1'b0;
      err     <= 1'b0;
      short_f <= 1'b0;
      bcount  <= '0;
    end else begin
      rvalid <= 1'b0;
      if (state == ACCUM && bus.frame_abort) begin
        state <= IDLE;
        crc   <= INIT_VALUE;
        cnt   <= '0;
      end else if (accept) begin
        crc <= crc_next;
        cnt <= cnt_next;
        if (bus.data_last) begin
          // Results are registered on entry so they are valid throughout REPORT.
          state   <= REPORT;
          rvalid  <= 1'b1;
          bcount  <= cnt_next;
          short_f <= is_short;
          ok      <= good;
          err     <= ~good;
        end else begin
          state <= ACCUM;
        end
      end else if (state == REPORT) begin
        state <= IDLE;
        crc   <= INIT_VALUE;
        cnt   <= '0;
      end
    end
  end

  assign bus.crc_out      = crc;
  assign bus.busy         = (state == ACCUM);
  assign bus.result_valid = rvalid;
  assign bus.crc_ok       = ok;
  assign bus.crc_error    = err;
  assign bus.short_frame  = short_f;
  assign bus.byte_count   = bcount;
endmodule

// File: doc/crc16_ccitt_checker.md
Name: crc16_ccitt_checker

Overview:
- Receive-side counterpart of the crc16_CCITT generator.
- Consumes a byte-framed stream whose last two bytes are the CRC-16-CCITT appended MSB first.
- Runs the residue check and reports pass/fail once per frame.
- Sits behind the byte receiver and in front of the packet buffer, which uses crc_ok to commit or discard the frame.

Parameters:
- POLY, 16'h1021, generator polynomial (normal, non-reflected form)
- INIT_VALUE, 16'hFFFF, CRC register value at start of each frame
- MIN_LEN, 3, minimum legal frame length in bytes (payload of at least 1 byte plus 2 CRC bytes)
- CNT_WIDTH, 16, width of the byte counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- sync_reset  in  1  synchronous, active-high reset
- data_valid  in  1  data_in carries a frame byte this cycle
- data_last  in  1  qualifies data_valid; this byte is the final byte of the frame (the CRC LSB)
- frame_abort  in  1  discard the frame in progress; no result is reported
- data_in  in  8  frame byte, MSB processed first
- crc_out  out  16  running CRC register
- busy  out  1  high while a frame is in progress (state ACCUM)
- result_valid  out  1  one-cycle pulse; crc_ok, crc_error, short_frame and byte_count are valid
- crc_ok  out  1  last frame passed (residue 0, length >= MIN_LEN); held until the next result
- crc_error  out  1  last frame failed (residue != 0 or short); held until the next result
- short_frame  out  1  last frame had fewer than MIN_LEN bytes; held until the next result
- byte_count  out  CNT_WIDTH  bytes in the last reported frame, CRC bytes included; held until the next result

Behaviour:
- Reset (sync_reset=1 at a clock edge):
  - state=IDLE, crc_out=INIT_VALUE, internal counter=0.
  - busy=0, result_valid=0, crc_ok=0, crc_error=0, short_frame=0, byte_count=0.
  - Reset overrides every other input, including mid-frame; the partial frame is discarded and no result is reported.
- CRC update, per accepted byte: 8 serial steps, MSB first.
  - Each step: fb = crc[15] ^ d[i]; crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0).
  - No reflection, no final XOR.
  - Combinational over the byte; crc_out updates on the edge that accepts the byte.
- States:
  - IDLE:
    - data_valid & !frame_abort: crc = update(INIT_VALUE, data_in), counter=1, go to ACCUM.
    - If data_last is also high, go to REPORT instead (1-byte frame).
  - ACCUM:
    - data_valid & !frame_abort: crc = update(crc, data_in), counter += 1.
    - data_last: go to REPORT.
    - frame_abort: go to IDLE, crc_out=INIT_VALUE, no result.
    - Abort wins over a simultaneous data_valid; that byte is dropped.
    - Idle cycles (data_valid=0) hold all state.
  - REPORT, exactly one cycle:
    - result_valid=1.
    - byte_count = counter.
    - short_frame = (counter < MIN_LEN).
    - crc_ok = (crc == 16'h0000) & !short_frame.
    - crc_error = !crc_ok.
    - crc_out still shows the final residue.
    - If data_valid is high in this cycle, it is the first byte of the next frame: update from INIT_VALUE, counter=1, go to ACCUM (or REPORT if data_last). This gives back-to-back frames with zero gap.
    - Otherwise go to IDLE; crc_out returns to INIT_VALUE in the next cycle.
- Latency: result_valid asserts on the cycle after the edge that accepted the data_last byte.
- frame_abort in IDLE or REPORT: no effect, except that it drops a simultaneous data_valid byte.
- Counter saturates at 2^CNT_WIDTH-1. A saturated frame still reports, with byte_count at its maximum.
- data_last without data_valid is ignored.
- busy is derived from the registered state (ACCUM only).

Test Plan:
- Pass: bytes "123456789" (0x31..0x39) with no gaps, then 0x29, 0xB1 (last).
  - crc_out = 0x29B1 after the 9th byte.
  - Final residue 0x0000.
  - result_valid pulse; crc_ok=1, crc_error=0, short_frame=0, byte_count=11.
- Single-bit error: same frame with last byte 0xB0.
  - crc_out = 0x1021 during REPORT.
  - crc_ok=0, crc_error=1, byte_count=11.
- Short frame: 2 bytes 0x1D, 0x0F (last).
  - short_frame=1, crc_error=1, crc_ok=0, byte_count=2.
- Back-to-back: pass frame immediately followed, on the REPORT cycle, by the erroneous frame.
  - Two result_valid pulses 11 cycles apart.
  - First pulse crc_ok=1; second pulse crc_error=1; no byte lost.
- Abort and gaps: 5 bytes with idle cycles between them, then frame_abort together with data_valid, then the full pass frame.
  - No result_valid for the aborted frame.
  - busy drops the cycle after the abort.
  - Next frame reports crc_ok=1, byte_count=11.
- Reset mid-frame: sync_reset after 4 bytes.
  - Next cycle shows all outputs at reset values and crc_out=0xFFFF.
  - The pass frame sent afterwards yields crc_ok=1.
